// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM with registered read data.
// Define RAM_ARB_RMW_EN to enable byte-lane writes via read-modify-write; otherwise every write is a full word.
module ram_port_arbiter #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [1:0]    p0_be,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_rvalid,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [1:0]    p1_be,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_rvalid,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_d,
    output logic          ram_we,
    output logic          ram_sel,
    input  logic [DW-1:0] ram_q
);

    localparam int HW = DW / 2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RMW_WR = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic          ptr_reg, ptr_next;
    logic          win_reg, win_next;
    logic          we_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;

    logic [1:0]    req;
    logic          we_in    [2];
    logic [AW-1:0] addr_in  [2];
    logic [DW-1:0] wdata_in [2];

    logic          lane_full;
    logic          lane_partial;
    logic          gnt_any;
    logic          rd_fire;
    logic [1:0]    gnt_vec;

    assign req         = {p1_req, p0_req};
    assign we_in[0]    = p0_we;
    assign we_in[1]    = p1_we;
    assign addr_in[0]  = p0_addr;
    assign addr_in[1]  = p1_addr;
    assign wdata_in[0] = p0_wdata;
    assign wdata_in[1] = p1_wdata;

`ifdef RAM_ARB_RMW_EN
    logic [1:0]    be_in [2];
    logic [1:0]    be_reg;
    logic [DW-1:0] merged_reg, merged_next;

    assign be_in[0]     = p0_be;
    assign be_in[1]     = p1_be;
    assign lane_full    = (be_reg == 2'b11);
    assign lane_partial = (be_reg == 2'b01) || (be_reg == 2'b10);

    // Merge is formed while the old word is on ram_q during ACCESS.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_lane
            assign merged_next[gi*HW +: HW] = be_reg[gi] ? wdata_reg[gi*HW +: HW]
                                                         : ram_q[gi*HW +: HW];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            be_reg     <= 2'b00;
            merged_reg <= '0;
        end else begin
            if (state_reg == IDLE && req != 2'b00) begin
                be_reg <= be_in[win_next];
            end
            if (state_reg == ACCESS) begin
                merged_reg <= merged_next;
            end
        end
    end

    assign ram_d = (state_reg == RMW_WR) ? merged_reg : wdata_reg;
`else
    logic unused_be;
    assign unused_be    = ^{p0_be, p1_be};
    assign lane_full    = 1'b1;
    assign lane_partial = 1'b0;
    assign ram_d        = wdata_reg;
`endif

    // Tie goes to the pointer; a lone requester always wins.
    always_comb begin
        win_next = ptr_reg;
        if (req == 2'b01) begin
            win_next = 1'b0;
        end else if (req == 2'b10) begin
            win_next = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req != 2'b00) state_next = ACCESS;
            ACCESS:  state_next = (we_reg && lane_partial) ? RMW_WR : IDLE;
            RMW_WR:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign gnt_any  = (state_reg == RMW_WR) ||
                      (state_reg == ACCESS && !(we_reg && lane_partial));
    assign rd_fire  = (state_reg == ACCESS) && !we_reg;
    assign ptr_next = gnt_any ? ~win_reg : ptr_reg;

    assign ram_sel  = (state_reg != IDLE);
    assign ram_we   = (state_reg == RMW_WR) ||
                      (state_reg == ACCESS && we_reg && lane_full);
    assign ram_addr = addr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
            win_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            // Command is captured only here so later input changes cannot disturb the access.
            if (state_reg == IDLE && req != 2'b00) begin
                win_reg   <= win_next;
                we_reg    <= we_in[win_next];
                addr_reg  <= addr_in[win_next];
                wdata_reg <= wdata_in[win_next];
            end
        end
    end

    genvar pi;
    generate
        for (pi = 0; pi < 2; pi++) begin : gen_port
            logic [DW-1:0] rdata_reg;
            logic          rvalid_reg;

            assign gnt_vec[pi] = gnt_any && (win_reg == 1'(pi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_reg  <= '0;
                    rvalid_reg <= 1'b0;
                end else begin
                    rvalid_reg <= rd_fire && (win_reg == 1'(pi));
                    if (rd_fire && (win_reg == 1'(pi))) begin
                        rdata_reg <= ram_q;
                    end
                end
            end
        end
    endgenerate

    assign p0_gnt    = gnt_vec[0];
    assign p1_gnt    = gnt_vec[1];
    assign p0_rdata  = gen_port[0].rdata_reg;
    assign p1_rdata  = gen_port[1].rdata_reg;
    assign p0_rvalid = gen_port[0].rvalid_reg;
    assign p1_rvalid = gen_port[1].rvalid_reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM and queue-based grant/read-data scoreboard.
module tb_ram_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;

`ifdef RAM_ARB_RMW_EN
    localparam int PLAT = 2;
`else
    localparam int PLAT = 1;
`endif

    logic          clk, rst_n;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [1:0]    p0_be, p1_be;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d, ram_q;
    logic          ram_we, ram_sel;

    logic [DW-1:0] mem [1024];
    int            gnt_q[$];
    logic [DW-1:0] rq0[$];
    logic [DW-1:0] rq1[$];
    int            checks = 0;
    int            failures = 0;
    int            we_cnt = 0;

    ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_sel(ram_sel),
        .ram_q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_q = mem[ram_addr];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= '0;
        mem[10'h005] <= 16'h1234;
        mem[10'h010] <= 16'h5678;
        mem[10'h020] <= 16'hCDEF;
        mem[10'h030] <= 16'h4321;
    end

    always @(posedge clk) begin
        if (ram_sel && ram_we) mem[ram_addr] <= ram_d;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: pops expected grants and read data whenever the DUT presents them.
    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt++;
            check("we_without_sel", ram_sel, 1);
        end
        if (p0_gnt || p1_gnt) check("single_gnt", p0_gnt & p1_gnt, 0);
        if (p0_gnt || p1_gnt) begin
            if (gnt_q.size() == 0) check("unexpected_gnt", 1, 0);
            else check("gnt_port", p1_gnt ? 1 : 0, gnt_q.pop_front());
        end
        if (p0_rvalid) begin
            if (rq0.size() == 0) check("unexpected_p0_rvalid", 1, 0);
            else check("p0_rdata", p0_rdata, rq0.pop_front());
        end
        if (p1_rvalid) begin
            if (rq1.size() == 0) check("unexpected_p1_rvalid", 1, 0);
            else check("p1_rdata", p1_rdata, rq1.pop_front());
        end
    end

    task automatic drive(input int p, input logic r, input logic we, input logic [1:0] be,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (p == 0) begin
            p0_req = r; p0_we = we; p0_be = be; p0_addr = a; p0_wdata = wd;
        end else begin
            p1_req = r; p1_we = we; p1_be = be; p1_addr = a; p1_wdata = wd;
        end
    endtask

    task automatic op(input int p, input logic we, input logic [1:0] be, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input int exp_lat,
                      input bit perturb, input string nm);
        int   k;
        logic g;
        gnt_q.push_back(p);
        if (!we) begin
            if (p == 0) rq0.push_back(exp_rd);
            else rq1.push_back(exp_rd);
        end
        @(posedge clk); #1 drive(p, 1'b1, we, be, a, wd);
        @(posedge clk);
        if (perturb) begin
            #1 drive(p, 1'b1, we, ~be, a ^ 10'h001, ~wd);
        end
        k = 0;
        g = 1'b0;
        while (!g && k < 8) begin
            @(negedge clk);
            k++;
            g = (p == 0) ? p0_gnt : p1_gnt;
        end
        check({nm, "_gnt_latency"}, k, exp_lat);
        @(posedge clk); #1 drive(p, 1'b0, 1'b0, 2'b00, '0, '0);
        if (!we) begin
            @(negedge clk);
            check({nm, "_rvalid"}, (p == 0) ? p0_rvalid : p1_rvalid, 1);
        end
    endtask

    initial begin
        int n, cyc, last, w0;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 2'b00, '0, '0);
        drive(1, 1'b0, 1'b0, 2'b00, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", {p0_gnt, p1_gnt}, 0);
        check("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
        check("rst_ram_sel_we", {ram_sel, ram_we}, 0);
        check("rst_rdata", {p0_rdata, p1_rdata}, 0);
        @(negedge clk); rst_n = 1'b1;

        // Both ports request continuously: grants must alternate starting at p0.
        for (int i = 0; i < 8; i++) gnt_q.push_back(i % 2);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 2'b11, 10'h100, 16'h1111);
        drive(1, 1'b1, 1'b1, 2'b11, 10'h101, 16'h2222);
        n = 0; cyc = 0; last = -1;
        while (n < 8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (p0_gnt || p1_gnt) begin
                n++;
                if (last >= 0) check("rr_spacing", cyc - last, 2);
                last = cyc;
            end
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 2'b00, '0, '0);
        drive(1, 1'b0, 1'b0, 2'b00, '0, '0);
        check("rr_grant_count", n, 8);
        check("rr_mem_p0", mem[10'h100], 16'h1111);
        check("rr_mem_p1", mem[10'h101], 16'h2222);

        op(0, 1'b0, 2'b00, 10'h005, 16'h0000, 16'h1234, 1, 1'b0, "p0_read_005");

        w0 = we_cnt;
        op(1, 1'b1, 2'b11, 10'h3FF, 16'hBEEF, 16'h0000, 1, 1'b0, "p1_write_3ff");
        check("full_write_we_cycles", we_cnt - w0, 1);
        op(1, 1'b0, 2'b00, 10'h3FF, 16'h0000, 16'hBEEF, 1, 1'b0, "p1_read_3ff");
        check("loser_rdata_hold", p0_rdata, 16'h1234);

`ifdef RAM_ARB_RMW_EN
        op(0, 1'b1, 2'b10, 10'h005, 16'hAB00, 16'h0000, PLAT, 1'b0, "p0_be10");
        check("mem_be10", mem[10'h005], 16'hAB34);
        op(1, 1'b1, 2'b01, 10'h020, 16'h1234, 16'h0000, PLAT, 1'b0, "p1_be01");
        check("mem_be01", mem[10'h020], 16'hCD34);
        op(0, 1'b1, 2'b00, 10'h030, 16'h9999, 16'h0000, 1, 1'b0, "p0_be00");
        check("mem_be00", mem[10'h030], 16'h4321);
`else
        op(0, 1'b1, 2'b10, 10'h005, 16'hAB00, 16'h0000, PLAT, 1'b0, "p0_be10");
        check("mem_be10", mem[10'h005], 16'hAB00);
        op(1, 1'b1, 2'b01, 10'h020, 16'h1234, 16'h0000, PLAT, 1'b0, "p1_be01");
        check("mem_be01", mem[10'h020], 16'h1234);
        op(0, 1'b1, 2'b00, 10'h030, 16'h9999, 16'h0000, 1, 1'b0, "p0_be00");
        check("mem_be00", mem[10'h030], 16'h9999);
`endif

        // Inputs change right after the sample edge; the latched command must win.
        op(0, 1'b0, 2'b00, 10'h3FF, 16'h0000, 16'hBEEF, 1, 1'b1, "p0_read_latched");
        op(1, 1'b1, 2'b11, 10'h040, 16'h7777, 16'h0000, 1, 1'b1, "p1_write_latched");
        check("mem_latched_write", mem[10'h040], 16'h7777);
        check("mem_latched_other", mem[10'h041], 16'h0000);

        // Reset lands mid-write (RMW_WR when enabled, otherwise ACCESS).
        @(posedge clk); #1 drive(0, 1'b1, 1'b1, 2'b10, 10'h010, 16'hAB00);
        @(posedge clk);
`ifdef RAM_ARB_RMW_EN
        @(posedge clk);
`endif
        #2;
        check("pre_abort_sel", ram_sel, 1);
        rst_n = 1'b0;
        #1;
        check("abort_gnt", {p0_gnt, p1_gnt}, 0);
        check("abort_ram", {ram_sel, ram_we}, 0);
        check("abort_rdata", {p0_rdata, p1_rdata}, 0);
        check("abort_rvalid", {p0_rvalid, p1_rvalid}, 0);
        drive(0, 1'b0, 1'b0, 2'b00, '0, '0);
        @(posedge clk);
        @(negedge clk);
        check("abort_mem_unchanged", mem[10'h010], 16'h5678);
        rst_n = 1'b1;
        op(0, 1'b0, 2'b00, 10'h010, 16'h0000, 16'h5678, 1, 1'b0, "p0_read_after_abort");

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("gnt_queue_empty", gnt_q.size(), 0);
        check("rd_queues_empty", rq0.size() + rq1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
